data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory model for a single-cycle core.
// Address map (word decode on addr[31:2]):
//   0x0000_0000-0x0000_0FFF  RAM, 1024 x 32, async read, sync write
//   0x8000_0000  CONSOLE   write: push byte; read: {24'b0, count, 2'b0, overflow, full}
//   0x8000_0004  CYCLE_LO  read-only low half of the 64-bit cycle counter
//   0x8000_0008  CYCLE_HI  read-only high half of the 64-bit cycle counter
//   0x8000_000C  HALT      write: halt with code; read: halt_code
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   addr, write_en, write_data core memory-stage request
//   read_data                  combinational load data for addr
//   cons_valid/cons_data/cons_ready  console FIFO head, popped on valid && ready
//   halted, halt_code          sticky halt flag and last HALT value
//   bad_access                 sticky flag for a store to an unmapped address
module data_mem_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        bad_access
);

    localparam int unsigned RAM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned CNT_W      = 4;

    localparam logic [29:0] CONSOLE_WORD  = 30'h2000_0000;
    localparam logic [29:0] CYCLE_LO_WORD = 30'h2000_0001;
    localparam logic [29:0] CYCLE_HI_WORD = 30'h2000_0002;
    localparam logic [29:0] HALT_WORD     = 30'h2000_0003;

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [63:0]      cycle_cnt;

    // Byte offset within the word plays no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // Address decode
    logic [29:0] word;
    logic        sel_ram;
    logic        sel_console;
    logic        sel_cycle_lo;
    logic        sel_cycle_hi;
    logic        sel_halt;
    logic        mapped;

    assign word         = addr[31:2];
    assign sel_ram      = (addr[31:12] == 20'd0);
    assign sel_console  = (word == CONSOLE_WORD);
    assign sel_cycle_lo = (word == CYCLE_LO_WORD);
    assign sel_cycle_hi = (word == CYCLE_HI_WORD);
    assign sel_halt     = (word == HALT_WORD);
    assign mapped       = sel_ram | sel_console | sel_cycle_lo | sel_cycle_hi | sel_halt;

    // FIFO control: a push into a full FIFO is accepted only when a pop frees a slot.
    logic fifo_full;
    logic push_req;
    logic push_acc;
    logic pop;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign cons_valid = (count != '0);
    assign cons_data  = fifo[rd_ptr];
    assign pop        = cons_valid & cons_ready;
    assign push_req   = write_en & sel_console;
    assign push_acc   = push_req & (~fifo_full | pop);

    // Combinational load path; reads never change state.
    always_comb begin
        read_data = 32'd0;
        if (sel_ram) begin
            read_data = ram[addr[11:2]];
        end else if (sel_console) begin
            read_data = {24'd0, count, 2'b00, overflow, fifo_full};
        end else if (sel_cycle_lo) begin
            read_data = cycle_cnt[31:0];
        end else if (sel_cycle_hi) begin
            read_data = cycle_cnt[63:32];
        end else if (sel_halt) begin
            read_data = halt_code;
        end
    end

    // RAM storage: not cleared by reset, stores suppressed during reset.
    always_ff @(posedge clk) begin
        if (!reset && write_en && sel_ram) begin
            ram[addr[11:2]] <= write_data;
        end
    end

    // FIFO storage: contents are discarded on reset through the pointers/count.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            fifo[wr_ptr] <= write_data[7:0];
        end
    end

    // Control state: FIFO pointers, cycle counter, halt and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            cycle_cnt  <= 64'd0;
            halted     <= 1'b0;
            halt_code  <= 32'd0;
            bad_access <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_acc) - CNT_W'(pop);
            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end
            if (!halted) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (write_en && sel_halt) begin
                halted    <= 1'b1;
                halt_code <= write_data;
            end
            if (write_en && !mapped) begin
                bad_access <= 1'b1;
            end
        end
    end

endmodule
